uart_msg_dispatcher: RTL and testbench

//  Sits after sync_uart_rx: captures each CRC-checked frame (opt, len, data)
//  on its one-cycle valid pulse, holds it in a one-deep buffer and delivers
//  it over valid/ready to one of N_DEST consumers chosen by the opt byte.

---
 rtl/uart_msg_dispatcher.sv | 124 ++++++++++++
 tb/tb_uart_msg_dispatcher.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/uart_msg_dispatcher.sv
// rtl/uart_msg_dispatcher.sv - one-deep frame buffer routing received frames to N_DEST consumers by opt byte
module uart_msg_dispatcher #(
    parameter int                   BYTE_SIZE = 8,
    parameter int                   DATA_W    = 64,
    parameter int                   N_DEST    = 4,
    parameter logic [BYTE_SIZE-1:0] OPT_BASE  = 8'h10,
    parameter int                   TIMEOUT   = 1024,
    parameter int                   CNT_W     = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 rx_valid,
    input  logic [BYTE_SIZE-1:0] rx_opt,
    input  logic [BYTE_SIZE-1:0] rx_len,
    input  logic [DATA_W-1:0]    rx_data,
    output logic [N_DEST-1:0]    dst_valid,
    input  logic [N_DEST-1:0]    dst_ready,
    output logic [BYTE_SIZE-1:0] dst_opt,
    output logic [BYTE_SIZE-1:0] dst_len,
    output logic [DATA_W-1:0]    dst_data,
    output logic                 busy,
    output logic [CNT_W-1:0]     unk_cnt,
    output logic [CNT_W-1:0]     ovr_cnt,
    output logic [CNT_W-1:0]     tmo_cnt
);
    localparam int IDX_W = (N_DEST > 1) ? $clog2(N_DEST) : 1;
    localparam int TMR_W = $clog2(TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_END = TMR_W'(TIMEOUT - 1);

    typedef enum logic {IDLE, DELIVER} state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [TMR_W-1:0]     timer_q, timer_d;
    logic [BYTE_SIZE-1:0] opt_q, opt_d, len_q, len_d;
    logic [DATA_W-1:0]    data_q, data_d;
    logic [CNT_W-1:0]     unk_q, unk_d, ovr_q, ovr_d, tmo_q, tmo_d;

    // Window check one bit wider than the opt byte so OPT_BASE+N_DEST cannot wrap.
    logic [BYTE_SIZE:0] opt_ext, base_ext, lim_ext, off_ext;
    logic               rx_known, xfer, accept;
    logic [IDX_W-1:0]   rx_idx;

    assign opt_ext  = {1'b0, rx_opt};
    assign base_ext = {1'b0, OPT_BASE};
    assign lim_ext  = (BYTE_SIZE+1)'(OPT_BASE + N_DEST);
    assign off_ext  = opt_ext - base_ext;
    assign rx_known = (opt_ext >= base_ext) && (opt_ext < lim_ext);
    assign rx_idx   = off_ext[IDX_W-1:0];

    assign dst_valid = (state_q == DELIVER) ? (N_DEST'(1) << idx_q) : '0;
    assign busy      = (state_q == DELIVER);
    assign dst_opt   = opt_q;
    assign dst_len   = len_q;
    assign dst_data  = data_q;
    assign unk_cnt   = unk_q;
    assign ovr_cnt   = ovr_q;
    assign tmo_cnt   = tmo_q;

    assign xfer   = |(dst_valid & dst_ready);
    // A frame arriving on the transfer cycle is taken as if the buffer were empty.
    assign accept = rx_valid && ((state_q == IDLE) || xfer);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        timer_d = timer_q;
        opt_d   = opt_q;
        len_d   = len_q;
        data_d  = data_q;
        unk_d   = unk_q;
        ovr_d   = ovr_q;
        tmo_d   = tmo_q;

        if (state_q == DELIVER) begin
            if (xfer) begin
                state_d = IDLE;
            end else if (timer_q == TMR_END) begin
                state_d = IDLE;
                if (tmo_q != '1) tmo_d = tmo_q + CNT_W'(1);
            end else begin
                timer_d = timer_q + TMR_W'(1);
            end
            if (rx_valid && !xfer && ovr_q != '1) ovr_d = ovr_q + CNT_W'(1);
        end

        if (accept) begin
            if (rx_known) begin
                state_d = DELIVER;
                idx_d   = rx_idx;
                timer_d = '0;
                opt_d   = rx_opt;
                len_d   = rx_len;
                data_d  = rx_data;
            end else if (unk_q != '1) begin
                unk_d = unk_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            idx_q   <= '0;
            timer_q <= '0;
            opt_q   <= '0;
            len_q   <= '0;
            data_q  <= '0;
            unk_q   <= '0;
            ovr_q   <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            timer_q <= timer_d;
            opt_q   <= opt_d;
            len_q   <= len_d;
            data_q  <= data_d;
            unk_q   <= unk_d;
            ovr_q   <= ovr_d;
            tmo_q   <= tmo_d;
        end
    end
endmodule

// File: tb/tb_uart_msg_dispatcher.sv
// tb/tb_uart_msg_dispatcher.sv - vector table plus scoreboard bench for uart_msg_dispatcher
module tb_uart_msg_dispatcher;
    localparam int TIMEOUT = 1024;

    logic        CLK, RST, rx_valid, busy;
    logic [7:0]  rx_opt, rx_len, dst_opt, dst_len, unk_cnt, ovr_cnt, tmo_cnt;
    logic [63:0] rx_data, dst_data;
    logic [3:0]  dst_valid, dst_ready;

    uart_msg_dispatcher dut (
        .CLK(CLK), .RST(RST), .rx_valid(rx_valid), .rx_opt(rx_opt), .rx_len(rx_len),
        .rx_data(rx_data), .dst_valid(dst_valid), .dst_ready(dst_ready), .dst_opt(dst_opt),
        .dst_len(dst_len), .dst_data(dst_data), .busy(busy), .unk_cnt(unk_cnt),
        .ovr_cnt(ovr_cnt), .tmo_cnt(tmo_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0]  opt;
        logic [7:0]  len;
        logic [63:0] data;
        logic        known;
        logic [3:0]  exp_valid;
    } vec_t;

    typedef struct {
        logic [3:0]  dest;
        logic [7:0]  opt;
        logic [7:0]  len;
        logic [63:0] data;
    } sb_t;

    sb_t  sb[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_unk = 0;
    vec_t vec[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [7:0] opt, input logic [7:0] len, input logic [63:0] data);
        rx_opt = opt; rx_len = len; rx_data = data; rx_valid = 1'b1;
    endtask

    always @(negedge CLK) begin
        if (!RST && (dst_valid & dst_ready) != 4'b0) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_delivery", {60'b0, dst_valid}, 64'b0);
            end else begin
                sb_t e;
                e = sb.pop_front();
                chk("sb_dest", {60'b0, dst_valid}, {60'b0, e.dest});
                chk("sb_opt", {56'b0, dst_opt}, {56'b0, e.opt});
                chk("sb_len", {56'b0, dst_len}, {56'b0, e.len});
                chk("sb_data", dst_data, e.data);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec[0] = '{8'h0F, 8'd1, 64'h1111, 1'b0, 4'b0000};
        vec[1] = '{8'h14, 8'd2, 64'h2222, 1'b0, 4'b0000};
        vec[2] = '{8'h12, 8'd3, 64'hA1B2C3, 1'b1, 4'b0100};
        vec[3] = '{8'h10, 8'd8, 64'hDEAD_BEEF_0123_4567, 1'b1, 4'b0001};
        vec[4] = '{8'h13, 8'd5, 64'h55AA, 1'b1, 4'b1000};
        vec[5] = '{8'h11, 8'd0, 64'h0, 1'b1, 4'b0010};
        vec[6] = '{8'h00, 8'd4, 64'h3333, 1'b0, 4'b0000};
        vec[7] = '{8'hFF, 8'd4, 64'h4444, 1'b0, 4'b0000};
        vec[8] = '{8'h90, 8'd4, 64'h5555, 1'b0, 4'b0000};

        RST = 1'b1; rx_valid = 1'b0; rx_opt = '0; rx_len = '0; rx_data = '0; dst_ready = '0;
        step(); step();
        RST = 1'b0;
        chk("rst_valid", {60'b0, dst_valid}, 64'h0);
        chk("rst_busy", {63'b0, busy}, 64'h0);
        chk("rst_data", dst_data, 64'h0);
        chk("rst_cnts", {40'b0, unk_cnt, ovr_cnt, tmo_cnt}, 64'h0);

        for (int i = 0; i < 9; i++) begin
            send(vec[i].opt, vec[i].len, vec[i].data);
            dst_ready = '0;
            if (vec[i].known) sb.push_back('{vec[i].exp_valid, vec[i].opt, vec[i].len, vec[i].data});
            else exp_unk++;
            step();
            rx_valid = 1'b0;
            chk("vec_valid", {60'b0, dst_valid}, {60'b0, vec[i].exp_valid});
            chk("vec_unk", {56'b0, unk_cnt}, 64'(exp_unk));
            if (vec[i].known) begin
                chk("vec_busy", {63'b0, busy}, 64'h1);
                chk("vec_data", dst_data, vec[i].data);
                dst_ready = 4'b1111;
                step();
                dst_ready = '0;
                chk("vec_done_busy", {63'b0, busy}, 64'h0);
                chk("vec_hold_opt", {56'b0, dst_opt}, {56'b0, vec[i].opt});
            end
        end

        // timeout drop: valid stays up for exactly TIMEOUT cycles
        send(8'h11, 8'd1, 64'h7777);
        step();
        rx_valid = 1'b0;
        for (int i = 0; i < TIMEOUT - 1; i++) step();
        chk("tmo_last_cycle_valid", {60'b0, dst_valid}, 64'h2);
        step();
        chk("tmo_dropped_valid", {60'b0, dst_valid}, 64'h0);
        chk("tmo_cnt_1", {56'b0, tmo_cnt}, 64'h1);

        // ready on the final timer cycle wins
        send(8'h11, 8'd2, 64'h8888);
        sb.push_back('{4'b0010, 8'h11, 8'd2, 64'h8888});
        step();
        rx_valid = 1'b0;
        for (int i = 0; i < TIMEOUT - 1; i++) step();
        dst_ready = 4'b0010;
        step();
        dst_ready = '0;
        chk("tmo_ready_busy", {63'b0, busy}, 64'h0);
        chk("tmo_cnt_keep", {56'b0, tmo_cnt}, 64'h1);

        // overrun, then back-to-back frame on the transfer cycle
        send(8'h10, 8'd1, 64'hF1);
        sb.push_back('{4'b0001, 8'h10, 8'd1, 64'hF1});
        step();
        send(8'h13, 8'd2, 64'hF2);
        step();
        rx_valid = 1'b0;
        chk("ovr_cnt_1", {56'b0, ovr_cnt}, 64'h1);
        chk("ovr_keep_valid", {60'b0, dst_valid}, 64'h1);
        chk("ovr_keep_data", dst_data, 64'hF1);
        send(8'h13, 8'd3, 64'hF3);
        sb.push_back('{4'b1000, 8'h13, 8'd3, 64'hF3});
        dst_ready = 4'b0001;
        step();
        rx_valid = 1'b0;
        dst_ready = '0;
        chk("b2b_valid", {60'b0, dst_valid}, 64'h8);
        chk("b2b_data", dst_data, 64'hF3);
        chk("b2b_ovr_keep", {56'b0, ovr_cnt}, 64'h1);
        // unknown frame on the transfer cycle returns to idle
        send(8'h50, 8'd0, 64'h0);
        exp_unk++;
        dst_ready = 4'b1000;
        step();
        rx_valid = 1'b0;
        dst_ready = '0;
        chk("xfer_unk_busy", {63'b0, busy}, 64'h0);
        chk("xfer_unk_cnt", {56'b0, unk_cnt}, 64'(exp_unk));

        // saturation
        send(8'h0F, 8'd0, 64'h0);
        for (int i = 0; i < 300; i++) begin
            step();
            exp_unk++;
        end
        rx_valid = 1'b0;
        chk("unk_saturate", {56'b0, unk_cnt}, (exp_unk > 255) ? 64'hFF : 64'(exp_unk));

        // reset mid-delivery
        send(8'h12, 8'd3, 64'hA1B2C3);
        step();
        rx_valid = 1'b0;
        chk("pre_rst_busy", {63'b0, busy}, 64'h1);
        RST = 1'b1;
        step();
        RST = 1'b0;
        chk("mid_rst_valid", {60'b0, dst_valid}, 64'h0);
        chk("mid_rst_busy", {63'b0, busy}, 64'h0);
        chk("mid_rst_fields", {48'b0, dst_opt, dst_len}, 64'h0);
        chk("mid_rst_data", dst_data, 64'h0);
        chk("mid_rst_cnts", {40'b0, unk_cnt, ovr_cnt, tmo_cnt}, 64'h0);
        step();
        chk("sb_empty", 64'(sb.size()), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
